// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and LSU results into a single register-file write port.
//
// The LSU wins a contested cycle by default. The ALU is forced through after STARVE_LIMIT
// consecutive contested LSU grants. The granted result is registered and presented on
// rf_* one cycle later. The registered write also feeds a two-port bypass query.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_valid/rd/data, ready   ALU result handshake
//   lsu_valid/rd/data, ready   load result handshake
//   rf_we/waddr/wdata          registered register-file write port
//   byp_raddr1/2               bypass query addresses
//   byp_hit1/2, byp_data       query matches the write in flight, and its data
module writeback_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,

    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,

    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,

    input  logic [ADDR_WIDTH-1:0] byp_raddr1,
    input  logic [ADDR_WIDTH-1:0] byp_raddr2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_WIDTH-1:0] byp_data
);

    localparam int unsigned StreakW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

    logic [StreakW-1:0]    streak_q, streak_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic                  grant_alu, grant_lsu;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    // ALU wins when it is alone or when the LSU has used up its contested-win budget.
    always_comb begin
        grant_alu = alu_valid && (!lsu_valid || (streak_q == StreakMax));
        grant_lsu = lsu_valid && !grant_alu;
        sel_rd    = grant_alu ? alu_rd : lsu_rd;
        sel_data  = grant_alu ? alu_data : lsu_data;
    end

    // Readies are gated by reset so nothing handshakes while the block is held in reset.
    assign alu_ready = rst_n && grant_alu;
    assign lsu_ready = rst_n && grant_lsu;

    always_comb begin
        streak_d = streak_q;
        if (!alu_valid || grant_alu) begin
            streak_d = '0;
        end else if (grant_lsu && (streak_q != StreakMax)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Writes to x0 are consumed and still update address/data, but never assert the enable.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_alu || grant_lsu) begin
            rf_we_d    = (sel_rd != '0);
            rf_waddr_d = sel_rd;
            rf_wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            streak_q   <= streak_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    assign byp_hit1 = rf_we_q && (rf_waddr_q == byp_raddr1) && (byp_raddr1 != '0);
    assign byp_hit2 = rf_we_q && (rf_waddr_q == byp_raddr2) && (byp_raddr2 != '0);
    assign byp_data = rf_wdata_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a driver applies directed and random traffic,
// a reference model pushes expected per-cycle responses, and a monitor compares them.
module tb_writeback_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned LIMIT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, lsu_valid;
    logic [AW-1:0] alu_rd, lsu_rd;
    logic [DW-1:0] alu_data, lsu_data;
    logic          alu_ready, lsu_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] byp_raddr1, byp_raddr2;
    logic          byp_hit1, byp_hit2;
    logic [DW-1:0] byp_data;

    writeback_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .byp_raddr1(byp_raddr1),
        .byp_raddr2(byp_raddr2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data  (byp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          alu_rdy;
        logic          lsu_rdy;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
    } rdy_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } out_t;

    rdy_t          rdy_q[$];
    out_t          out_q[$];
    logic [AW-1:0] wlog[$];

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    // Reference state: count of contested LSU wins since the ALU last won or went idle,
    // plus the write the register port should be showing next cycle.
    int   lsu_wins = 0;
    out_t m_out = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                               input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                               output logic ga, output logic gl);
        rdy_t r;
        alu_valid  = av;  alu_rd = ard;  alu_data = adat;
        lsu_valid  = lv;  lsu_rd = lrd;  lsu_data = ldat;
        byp_raddr1 = r1;  byp_raddr2 = r2;
        // A lone requester always wins; under contention the LSU wins until it has
        // collected LIMIT wins in a row, then the ALU gets one.
        if (av && lv) begin
            ga = (lsu_wins >= LIMIT);
            gl = !ga;
        end else begin
            ga = av;
            gl = lv;
        end
        r.alu_rdy = ga;
        r.lsu_rdy = gl;
        r.r1 = r1;
        r.r2 = r2;
        rdy_q.push_back(r);
        if (!av || ga) lsu_wins = 0;
        else if (gl && lsu_wins < LIMIT) lsu_wins++;
        if (ga) m_out = '{we: (ard != 0), addr: ard, data: adat};
        else if (gl) m_out = '{we: (lrd != 0), addr: lrd, data: ldat};
        else m_out.we = 1'b0;
        out_q.push_back(m_out);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        logic ga, gl;
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, r1, r2, ga, gl);
    endtask

    task automatic check_log(input string name, input logic [AW-1:0] exp[$]);
        chk({name, "_len"}, 64'(wlog.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < wlog.size(); i++) begin
            chk($sformatf("%s_%0d", name, i), 64'(wlog[i]), 64'(exp[i]));
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rdy_q.size() == 0 || out_q.size() == 0) begin
                chk("sb_underflow", 64'(rdy_q.size() * out_q.size()), 64'd1);
            end else begin
                rdy_t r;
                out_t o;
                r = rdy_q.pop_front();
                o = out_q.pop_front();
                chk("alu_ready", 64'(alu_ready), 64'(r.alu_rdy));
                chk("lsu_ready", 64'(lsu_ready), 64'(r.lsu_rdy));
                chk("rf_we",     64'(rf_we),     64'(o.we));
                chk("rf_waddr",  64'(rf_waddr),  64'(o.addr));
                chk("rf_wdata",  64'(rf_wdata),  64'(o.data));
                chk("byp_hit1",  64'(byp_hit1),  64'(o.we && o.addr == r.r1 && r.r1 != 0));
                chk("byp_hit2",  64'(byp_hit2),  64'(o.we && o.addr == r.r2 && r.r2 != 0));
                chk("byp_data",  64'(byp_data),  64'(o.data));
                if (rf_we) wlog.push_back(rf_waddr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic random_burst(input int n);
        logic          ga, gl, ha, hl, av, lv;
        logic [AW-1:0] ard, lrd, r1, r2;
        logic [DW-1:0] adat, ldat;
        ha = 1'b0; hl = 1'b0;
        ard = '0; lrd = '0; adat = '0; ldat = '0;
        for (int i = 0; i < n; i++) begin
            // A source left waiting keeps its valid and payload unchanged.
            av = ha ? 1'b1 : ($urandom_range(0, 9) < 6);
            lv = hl ? 1'b1 : ($urandom_range(0, 9) < 6);
            if (!ha) begin
                ard  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                adat = $urandom;
            end
            if (!hl) begin
                lrd  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                ldat = $urandom;
            end
            r1 = $urandom_range(0, 1) ? m_out.addr : AW'($urandom);
            r2 = $urandom_range(0, 1) ? m_out.addr : AW'($urandom);
            drive_cycle(av, ard, adat, lv, lrd, ldat, r1, r2, ga, gl);
            ha = av && !ga;
            hl = lv && !gl;
        end
    endtask

    initial begin
        logic          ga, gl;
        logic [AW-1:0] nxt;
        logic [AW-1:0] exp_log[$];

        rst_n = 1'b1;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
        byp_raddr1 = '0; byp_raddr2 = '0;
        #2 rst_n = 1'b0;
        #1;
        alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        chk("rst_rf_we",     64'(rf_we),     64'd0);
        chk("rst_rf_waddr",  64'(rf_waddr),  64'd0);
        chk("rst_rf_wdata",  64'(rf_wdata),  64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_rf_we", 64'(rf_we), 64'd0);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst_n = 1'b1;

        out_q.push_back('0);
        mon_en = 1'b1;

        // ALU only, then x0 load, then bypass hit/miss.
        drive_cycle(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, '0, '0, ga, gl);
        idle(5'd5, 5'd0);
        idle('0, '0);
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, '0, '0, ga, gl);
        idle('0, '0);
        drive_cycle(1'b1, 5'd7, 32'hCAFE, 1'b0, '0, '0, '0, '0, ga, gl);
        idle(5'd7, 5'd8);
        idle('0, '0);

        // Contention: LSU wins three times, then ALU once.
        wlog.delete();
        nxt = 5'd1;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 5'd9, 32'hA9, 1'b1, nxt, 32'(nxt) + 32'h100, '0, '0, ga, gl);
            if (gl) nxt = nxt + 1'b1;
        end
        idle('0, '0);
        idle('0, '0);
        exp_log = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd4};
        check_log("contention", exp_log);

        // An idle ALU cycle restarts the LSU win budget.
        wlog.delete();
        nxt = 5'd1;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 5'd9, 32'hA9, 1'b1, nxt, 32'(nxt), '0, '0, ga, gl);
            if (gl) nxt = nxt + 1'b1;
        end
        drive_cycle(1'b0, '0, '0, 1'b1, nxt, 32'(nxt), '0, '0, ga, gl);
        if (gl) nxt = nxt + 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 5'd9, 32'hA9, 1'b1, nxt, 32'(nxt), '0, '0, ga, gl);
            if (gl) nxt = nxt + 1'b1;
        end
        idle('0, '0);
        idle('0, '0);
        exp_log = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd7};
        check_log("streak_clear", exp_log);

        random_burst(300);
        idle('0, '0);
        mon_en = 1'b0;
        rdy_q.delete();
        out_q.delete();

        // Reset in the middle of a grant: the captured write must never appear.
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777;
        lsu_valid = 1'b0;
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h0BAD_F00D;
        @(negedge clk);
        chk("pre_rst_rf_we",    64'(rf_we),     64'd1);
        chk("pre_rst_rf_waddr", 64'(rf_waddr),  64'd7);
        chk("pre_rst_lsu_rdy",  64'(lsu_ready), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rf_we",    64'(rf_we),     64'd0);
        chk("mid_rst_rf_waddr", 64'(rf_waddr),  64'd0);
        chk("mid_rst_rf_wdata", 64'(rf_wdata),  64'd0);
        chk("mid_rst_lsu_rdy",  64'(lsu_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("in_rst_rf_we", 64'(rf_we), 64'd0);
        lsu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_rf_we_%0d", i), 64'(rf_we), 64'd0);
        end

        lsu_wins = 0;
        m_out = '0;
        out_q.push_back('0);
        mon_en = 1'b1;
        random_burst(200);
        idle('0, '0);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register address width.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 Parameter STARVE_LIMIT, default 3, consecutive contested LSU grants before ALU is forced.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 alu_valid  in  1  ALU result available.
REQ-007 alu_rd  in  ADDR_WIDTH  ALU destination register.
REQ-008 alu_data  in  DATA_WIDTH  ALU result.
REQ-009 alu_ready  out  1  ALU result accepted this cycle.
REQ-010 lsu_valid  in  1  load result available.
REQ-011 lsu_rd  in  ADDR_WIDTH  load destination register.
REQ-012 lsu_data  in  DATA_WIDTH  load data.
REQ-013 lsu_ready  out  1  load result accepted this cycle.
REQ-014 rf_we  out  1  register file write enable.
REQ-015 rf_waddr  out  ADDR_WIDTH  register file write address.
REQ-016 rf_wdata  out  DATA_WIDTH  register file write data.
REQ-017 byp_raddr1, byp_raddr2  in  ADDR_WIDTH  bypass query addresses.
REQ-018 byp_hit1, byp_hit2  out  1  query matches the write in flight.
REQ-019 byp_data  out  DATA_WIDTH  data of the write in flight.

Function
REQ-020 A transfer SHALL occur on a source when its valid and ready are both high at posedge clk.
REQ-021 At most one source SHALL be granted per cycle; ready SHALL be high only for the granted source and only while its valid is high.
REQ-022 Only one source valid: that source SHALL be granted in the same cycle; no backpressure otherwise exists.
REQ-023 Both valid: LSU SHALL be granted unless streak == STARVE_LIMIT, in which case ALU SHALL be granted.
REQ-024 streak (saturating, width ≥ clog2(STARVE_LIMIT+1)) SHALL increment on each cycle where LSU is granted while alu_valid is high.
REQ-025 streak SHALL clear to 0 on any ALU grant and on any cycle where alu_valid is low.
REQ-026 Output register: a granted transfer in cycle t SHALL appear on rf_waddr/rf_wdata in cycle t+1, with rf_we high in t+1 iff the granted rd != 0.
REQ-027 Granted transfer with rd == 0 SHALL be consumed (ready high), rf_we low in t+1; rf_waddr/rf_wdata SHALL still update.
REQ-028 No grant in cycle t: rf_we SHALL be low in t+1; rf_waddr/rf_wdata SHALL hold.
REQ-029 Back-to-back grants SHALL produce back-to-back rf_we pulses, one per cycle, no bubbles.
REQ-030 byp_hitN SHALL be combinational: rf_we && (rf_waddr == byp_raddrN) && (byp_raddrN != 0).
REQ-031 byp_data SHALL equal rf_wdata combinationally.
REQ-032 Inputs held while not ready SHALL not be sampled or altered; a source MAY change payload only after transfer.

Reset
REQ-033 rst_n low SHALL immediately force rf_we=0, rf_waddr=0, rf_wdata=0, streak=0, independent of clk.
REQ-034 During reset alu_ready and lsu_ready SHALL be 0.
REQ-035 A write captured before reset assertion and not yet presented SHALL be discarded; no rf_we pulse after rst_n rises until a new grant.
REQ-036 First grant is permitted on the first posedge clk with rst_n high.

Verification
REQ-037 ALU only: alu_valid=1, rd=5, data=0x1234 for 1 cycle -> alu_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; following cycle rf_we=0.
REQ-038 Contention: both valid continuously, LSU rd=1..n, ALU rd=9 -> grant order LSU,LSU,LSU,ALU,LSU... with STARVE_LIMIT=3; rf_waddr sequence 1,2,3,9,4.
REQ-039 x0 write: lsu_valid=1, rd=0, data=0xFFFFFFFF -> lsu_ready=1; next cycle rf_we=0, byp_hit1=0 with byp_raddr1=0.
REQ-040 Bypass: ALU rd=7 data=0xCAFE granted; next cycle byp_raddr1=7, byp_raddr2=8 -> byp_hit1=1, byp_hit2=0, byp_data=0xCAFE.
REQ-041 Reset mid-operation: grant LSU rd=3, assert rst_n low before next posedge -> rf_we=0, rf_waddr=0 immediately; after release with no valids, rf_we stays 0.
REQ-042 Streak clear: 2 contested LSU grants, one cycle alu_valid=0, then contention -> LSU granted 3 more times before ALU.
